// File: rtl/bit_stream_pkg.sv
// bit_stream_pkg: shared state encoding, period floor and PRBS7 constants for bit_stream_tx.
package bit_stream_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;
  localparam int MIN_PERIOD = 2;
  localparam logic [6:0] PRBS7_TAPS = 7'b1100000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], ^(s & PRBS7_TAPS)};
  endfunction
endpackage

// File: rtl/bit_stream_tx_bit_timer.sv
// bit_timer: free-running 0..period-1 bit timer with restart; strobe marks the first cycle, last the final one.
module bit_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                strobe,
  output logic                last
);
  logic [PERIOD_W-1:0] count;
  assign strobe = count == '0;
  assign last = count == period - 1'b1;
  always_ff @(posedge clk)
    count <= (rst || load || last) ? '0 : count + 1'b1;
endmodule

// File: rtl/bit_stream_tx.sv
// bit_stream_tx: NRZ serializer with alternating preamble and programmable bit period; PRBS_IDLE_EN fills IDLE with PRBS7.
module bit_stream_tx
  import bit_stream_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int PRE_LEN  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                tx_out,
  output logic                bit_strobe,
  output logic                tx_busy
);
  localparam int CNT_W = $clog2(PRE_LEN > DATA_W ? PRE_LEN : DATA_W);
  localparam logic [PERIOD_W-1:0] P_MIN = PERIOD_W'(MIN_PERIOD);
  state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [PERIOD_W-1:0] p_reg, p_in;
  logic t_strobe, t_last, pre_end, data_end, accept, idle_bit, idle_run;
  assign p_in = bit_period < P_MIN ? P_MIN : bit_period;
  assign pre_end = cnt == CNT_W'(PRE_LEN - 1);
  assign data_end = cnt == CNT_W'(DATA_W - 1);
  assign tx_busy = state != IDLE;
  assign in_ready = !rst && (state == IDLE || (state == DATA && t_last && data_end));
  assign accept = in_valid && in_ready;
  assign bit_strobe = t_strobe && (tx_busy || idle_run);
  bit_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(accept && state == IDLE),
    .period(p_reg),
    .strobe(t_strobe),
    .last(t_last)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (accept ? PREAMBLE : IDLE)
      : (state == PREAMBLE) ? ((t_last && pre_end) ? DATA : PREAMBLE)
      : (state == DATA) ? ((t_last && data_end && !accept) ? IDLE : DATA)
      : IDLE;
  end
  // A word accepted from DATA skips the preamble, so its MSB goes straight out.
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      p_reg <= P_MIN;
      tx_out <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      sr <= (state == IDLE) ? in_data : {in_data[DATA_W-2:0], 1'b0};
      tx_out <= (state == IDLE) ? 1'b1 : in_data[DATA_W-1];
      p_reg <= p_in;
    end else if (t_last) begin
      cnt <= ((state == PREAMBLE) ? pre_end : (state != DATA || data_end)) ? '0 : cnt + 1'b1;
      sr <= (state == PREAMBLE && !pre_end) ? sr : sr << 1;
      tx_out <= (state == PREAMBLE) ? (pre_end ? sr[DATA_W-1] : ~tx_out)
        : (state == DATA && !data_end) ? sr[DATA_W-1] : idle_bit;
    end
`ifdef PRBS_IDLE_EN
  logic [6:0] lfsr;
  // The LFSR only steps when an idle bit is emitted, so it stays frozen across frames.
  always_ff @(posedge clk)
    if (rst) begin
      lfsr <= PRBS7_SEED;
      idle_run <= 1'b0;
    end else if (t_last && !accept && (state == IDLE || (state == DATA && data_end))) begin
      lfsr <= prbs7_next(lfsr);
      idle_run <= 1'b1;
    end
  assign idle_bit = lfsr[6];
`else
  assign idle_bit = 1'b0;
  assign idle_run = 1'b0;
`endif
endmodule

// File: tb/tb_bit_stream_tx.sv
// tb_bit_stream_tx: randomized self-checking bench comparing the serial stream against a frame-level model.
module tb_bit_stream_tx;
  localparam int DW = 8, PW = 16, PL = 8;
  logic clk = 1'b0, rst, in_valid, in_ready, tx_out, bit_strobe, tx_busy;
  logic [PW-1:0] bit_period;
  logic [DW-1:0] in_data;
  int checks = 0, errors = 0;
  bit mon_bit[8192];
  int mon_len[8192];
  int mon_n = 0, mon_busy = 0, mon_strobes = 0, mon_glitch = 0, mon_rdy = 0, mon_rise = 0, idle_bad = 0;
  bit prev_busy = 1'b0;
  bit idle_q[$];
  bit exp_bit[1024];
  int exp_len[1024];
  int exp_n;
  logic [7:0] wq[$];
  int pq[$];
  bit gq[$];

  bit_stream_tx dut (
    .clk(clk), .rst(rst), .bit_period(bit_period), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx_out(tx_out), .bit_strobe(bit_strobe), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_busy && !prev_busy) mon_rise++;
    prev_busy = tx_busy;
    if (tx_busy && in_ready) mon_rdy++;
    if (tx_busy) begin
      mon_busy++;
      if (bit_strobe) begin
        if (mon_n < 8192) begin
          mon_bit[mon_n] = tx_out;
          mon_len[mon_n] = 1;
        end
        mon_n++;
        mon_strobes++;
      end else if (mon_n > 0 && mon_n <= 8192) begin
        mon_len[mon_n-1]++;
        if (tx_out !== mon_bit[mon_n-1]) mon_glitch++;
      end
    end else begin
      if (bit_strobe) idle_q.push_back(tx_out);
      if (tx_out !== 1'b0 || bit_strobe !== 1'b0) idle_bad++;
    end
  end

  task automatic model_word(input logic [7:0] w, input int bp, input bit preamble);
    int p;
    p = bp < 2 ? 2 : bp;
    if (preamble)
      for (int k = 0; k < PL; k++) begin
        exp_bit[exp_n] = (k % 2 == 0);
        exp_len[exp_n] = p;
        exp_n++;
      end
    for (int b = DW - 1; b >= 0; b--) begin
      exp_bit[exp_n] = w[b];
      exp_len[exp_n] = p;
      exp_n++;
    end
  endtask

  function automatic int stream_diff(input int s);
    int d;
    d = (mon_n - s != exp_n) ? 1 : 0;
    for (int i = 0; i < exp_n && s + i < mon_n; i++)
      if (mon_bit[s+i] != exp_bit[i] || mon_len[s+i] != exp_len[i]) d++;
    return d;
  endfunction

  function automatic int exp_cycles();
    int c = 0;
    for (int i = 0; i < exp_n; i++) c += exp_len[i];
    return c;
  endfunction

  task automatic wait_idle(output bit ok);
    int t = 0;
    while (tx_busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    ok = !tx_busy;
  endtask

  task automatic drive(output bit ok);
    bit ok2;
    int t;
    ok = 1;
    exp_n = 0;
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = wq[i];
      bit_period = PW'(pq[i]);
      model_word(wq[i], pq[i], i == 0 || gq[i-1]);
      t = 0;
      while (!in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) ok = 0;
      @(posedge clk);
      if (gq[i] || i == wq.size() - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
        wait_idle(ok2);
        ok &= ok2;
      end
    end
    @(posedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_out, tx_busy, bit_strobe, in_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold: {tx_out,busy,strobe,ready}=%b want 0000", {tx_out, tx_busy, bit_strobe, in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, tx_busy, tx_out} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: {ready,busy,tx_out}=%b want 100", {in_ready, tx_busy, tx_out});
    end
  endtask

  task automatic test_single();
    int s, b0, st0, g0, r0;
    bit ok;
    logic [15:0] got;
    @(posedge clk);
    s = mon_n; b0 = mon_busy; st0 = mon_strobes; g0 = mon_glitch; r0 = mon_rdy;
    wq = '{8'hA5}; pq = '{4}; gq = '{1'b1};
    drive(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: ok=%0d want 1", ok); end
    checks++;
    if (stream_diff(s) !== 0) begin errors++; $display("FAIL single_stream: %0d diffs, got %0d bits want %0d", stream_diff(s), mon_n - s, exp_n); end
    for (int i = 0; i < 16; i++) got[15-i] = mon_bit[s+i];
    checks++;
    if (got !== 16'b1010101010100101) begin errors++; $display("FAIL single_pattern: got %b want 1010101010100101", got); end
    checks++;
    if (mon_busy - b0 !== 64) begin errors++; $display("FAIL single_busy: got %0d cycles want 64", mon_busy - b0); end
    checks++;
    if (mon_strobes - st0 !== 16) begin errors++; $display("FAIL single_strobes: got %0d want 16", mon_strobes - st0); end
    checks++;
    if (mon_glitch - g0 !== 0 || mon_rdy - r0 !== 1) begin errors++; $display("FAIL single_glitch_ready: glitches %0d ready %0d want 0 and 1", mon_glitch - g0, mon_rdy - r0); end
`ifndef PRBS_IDLE_EN
    checks++;
    if ({tx_busy, tx_out} !== 2'b00) begin errors++; $display("FAIL single_idle: {busy,tx_out}=%b want 00", {tx_busy, tx_out}); end
`endif
  endtask

  task automatic test_back_to_back();
    int s, b0, r0, rs0;
    bit ok;
    @(posedge clk);
    s = mon_n; b0 = mon_busy; r0 = mon_rdy; rs0 = mon_rise;
    wq = '{8'hFF, 8'h00}; pq = '{3, 3}; gq = '{1'b0, 1'b1};
    drive(ok);
    checks++;
    if (!ok || stream_diff(s) !== 0) begin errors++; $display("FAIL b2b_stream: ok=%0d diffs=%0d want 1 and 0", ok, stream_diff(s)); end
    checks++;
    if (mon_busy - b0 !== 72 || mon_rise - rs0 !== 1) begin errors++; $display("FAIL b2b_gap: busy %0d runs %0d want 72 and 1", mon_busy - b0, mon_rise - rs0); end
    checks++;
    if (mon_rdy - r0 !== 2) begin errors++; $display("FAIL b2b_ready: got %0d busy-ready cycles want 2", mon_rdy - r0); end
  endtask

  task automatic test_clamp();
    int s, t;
    bit ok;
    logic [7:0] w;
    @(posedge clk);
    s = mon_n;
    wq = '{8'($urandom), 8'($urandom)}; pq = '{0, 1}; gq = '{1'b1, 1'b1};
    drive(ok);
    checks++;
    if (!ok || stream_diff(s) !== 0) begin errors++; $display("FAIL clamp_stream: ok=%0d diffs=%0d want 1 and 0", ok, stream_diff(s)); end
    s = mon_n;
    w = 8'($urandom);
    exp_n = 0;
    model_word(w, 5, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; bit_period = 16'd5;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    bit_period = 16'd10;
    wait_idle(ok);
    @(posedge clk);
    checks++;
    if (!ok || stream_diff(s) !== 0) begin errors++; $display("FAIL freeze_stream: ok=%0d diffs=%0d want 1 and 0", ok, stream_diff(s)); end
  endtask

  task automatic test_reset_mid();
    int s, k, t;
    bit ok;
    @(posedge clk);
    s = mon_n;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'($urandom); bit_period = 16'd4;
    k = 0; t = 0;
    while (k < PL + 4 && t < 500) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (bit_strobe && tx_busy) k++;
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx_out, tx_busy, bit_strobe, in_ready} !== 4'b0) begin errors++; $display("FAIL rstmid_abort: {tx_out,busy,strobe,ready}=%b want 0000", {tx_out, tx_busy, bit_strobe, in_ready}); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
    checks++;
    if (mon_n - s !== PL + 4 || mon_len[s+PL+3] !== 1) begin errors++; $display("FAIL rstmid_partial: bits %0d last len %0d want %0d and 1", mon_n - s, mon_len[s+PL+3], PL + 4); end
    s = mon_n;
    wq = '{8'($urandom)}; pq = '{$urandom_range(0, 5)}; gq = '{1'b1};
    drive(ok);
    checks++;
    if (!ok || stream_diff(s) !== 0) begin errors++; $display("FAIL rstmid_next: ok=%0d diffs=%0d want 1 and 0", ok, stream_diff(s)); end
  endtask

  task automatic test_handshake();
    int s, t, rs0, busy_seen;
    logic [7:0] w;
    @(posedge clk);
    s = mon_n; rs0 = mon_rise;
    w = 8'($urandom);
    exp_n = 0;
    model_word(w, 3, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; bit_period = 16'd3;
    @(negedge clk);
    t = 0;
    while (tx_busy && t < 1000) begin
      in_valid = (tx_busy && !in_ready) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data = 8'($urandom);
      bit_period = 16'($urandom_range(0, 9));
      @(negedge clk);
      in_valid = 1'b0;
      t++;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (stream_diff(s) !== 0 || mon_rise - rs0 !== 1) begin errors++; $display("FAIL handshake_extra: diffs=%0d frames=%0d want 0 and 1", stream_diff(s), mon_rise - rs0); end
    s = mon_n;
    rst = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    busy_seen = 0;
    repeat (30) begin @(negedge clk); if (tx_busy) busy_seen++; end
    checks++;
    if (busy_seen !== 0 || mon_n !== s) begin errors++; $display("FAIL handshake_rst_drop: busy %0d bits %0d want 0 and 0", busy_seen, mon_n - s); end
  endtask

  task automatic test_random();
    int s, b0, r0, rs0, n, frames;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      s = mon_n; b0 = mon_busy; r0 = mon_rdy; rs0 = mon_rise;
      wq.delete(); pq.delete(); gq.delete();
      n = $urandom_range(2, 4);
      frames = 1;
      for (int i = 0; i < n; i++) begin
        wq.push_back(8'($urandom));
        pq.push_back($urandom_range(0, 5));
        gq.push_back(1'($urandom_range(0, 1)));
        if (i < n - 1 && gq[i]) frames++;
      end
      drive(ok);
      checks++;
      if (!ok || stream_diff(s) !== 0) begin errors++; $display("FAIL random%0d_stream: ok=%0d diffs=%0d want 1 and 0", r, ok, stream_diff(s)); end
      checks++;
      if (mon_busy - b0 !== exp_cycles() || mon_rise - rs0 !== frames || mon_rdy - r0 !== n) begin
        errors++;
        $display("FAIL random%0d_timing: busy %0d frames %0d ready %0d want %0d %0d %0d", r, mon_busy - b0, mon_rise - rs0, mon_rdy - r0, exp_cycles(), frames, n);
      end
    end
    checks++;
    if (mon_glitch !== 0) begin errors++; $display("FAIL glitch_total: got %0d want 0", mon_glitch); end
  endtask

  task automatic test_idle_fill();
`ifdef PRBS_IDLE_EN
    int q0, n, d;
    bit ok;
    bit ref_seq[256];
    for (int i = 0; i < 7; i++) ref_seq[i] = 1'b1;
    for (int i = 0; i + 7 < 256; i++) ref_seq[i+7] = ref_seq[i] ^ ref_seq[i+1];
    reset_dut();
    q0 = idle_q.size();
    repeat (40) @(negedge clk);
    wq = '{8'($urandom)}; pq = '{2}; gq = '{1'b1};
    drive(ok);
    repeat (40) @(negedge clk);
    @(posedge clk);
    n = idle_q.size() - q0;
    d = 0;
    for (int i = 0; i < n && i < 256; i++) if (idle_q[q0+i] !== ref_seq[i]) d++;
    checks++;
    if (n < 14 || d !== 0) begin errors++; $display("FAIL prbs_first14: %0d idle bits %0d wrong before n=%0d", n, d, n); end
    checks++;
    if (!ok || n < 30) begin errors++; $display("FAIL prbs_resume: ok=%0d idle bits %0d want >=30", ok, n); end
`else
    repeat (30) @(negedge clk);
    checks++;
    if (idle_bad !== 0) begin errors++; $display("FAIL idle_quiet: %0d idle cycles with tx_out/strobe high want 0", idle_bad); end
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; bit_period = 16'd4;
    test_reset();
    test_single();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_handshake();
    test_random();
    test_idle_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
